// File: rtl/multi_dose_pkg.sv
// Shared types and helpers for the multi-channel dose scheduler.
package multi_dose_pkg;

    localparam int DEF_N_CHAN = 4;
    localparam int DEF_ID_W   = $clog2(DEF_N_CHAN);

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_COUNT  = 2'd1,
        CH_ALARM  = 2'd2,
        CH_SNOOZE = 2'd3
    } ch_state_e;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned width);
        int unsigned max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/dose_channel.sv
// One medication channel: interval countdown, alarm/ack-timeout FSM, missed counter.
// Snooze state is built only with MULTI_DOSE_SCHEDULER_SNOOZE_EN.
module dose_channel
    import multi_dose_pkg::*;
#(
    parameter int CNT_W        = 17,
    parameter int DOSE_W       = 4,
    parameter int MISS_W       = 4,
    parameter int ACK_TIMEOUT  = 900,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              cfg_hit,
    input  logic [CNT_W-1:0]  cfg_interval,
    input  logic [DOSE_W-1:0] cfg_dose,
    input  logic              ack_hit,
    input  logic              snooze_hit,
    output logic              pending,
    output logic [DOSE_W-1:0] dose,
    output logic [MISS_W-1:0] missed
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    ch_state_e         state;
    logic [CNT_W-1:0]  interval;
    logic [CNT_W-1:0]  remain;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              expire;
    logic              timeout;
    logic [MISS_W-1:0] missed_inc;

    assign expire     = tick && (remain == CNT_W'(1));
    assign wait_nxt   = wait_cnt + 1'b1;
    assign timeout    = tick && (wait_nxt == WAIT_W'(ACK_TIMEOUT));
    assign missed_inc = MISS_W'(sat_inc(32'(missed), unsigned'(MISS_W)));
    assign pending    = (state == CH_ALARM);

`ifdef MULTI_DOSE_SCHEDULER_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_TICKS + 1);
    logic [SNZ_W-1:0] snz_cnt;
`else
    // Snooze port and delay stay on the interface so both builds share one pinout.
    logic unused_snooze;
    assign unused_snooze = snooze_hit | (SNOOZE_TICKS != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CH_IDLE;
            interval <= '0;
            remain   <= '0;
            wait_cnt <= '0;
            dose     <= '0;
            missed   <= '0;
`ifdef MULTI_DOSE_SCHEDULER_SNOOZE_EN
            snz_cnt  <= '0;
`endif
        end else if (cfg_hit) begin
            interval <= cfg_interval;
            remain   <= cfg_interval;
            dose     <= cfg_dose;
            wait_cnt <= '0;
            state    <= (cfg_interval != '0) ? CH_COUNT : CH_IDLE;
        end else if (state != CH_IDLE) begin
            // The interval keeps running in every active state, ack cycles included.
            if (tick) remain <= expire ? interval : remain - 1'b1;
            if (ack_hit) begin
                state    <= expire ? CH_ALARM : CH_COUNT;
                wait_cnt <= '0;
            end else begin
                case (state)
                    CH_COUNT: begin
                        if (expire) begin
                            state    <= CH_ALARM;
                            wait_cnt <= '0;
                        end
                    end
                    CH_ALARM: begin
`ifdef MULTI_DOSE_SCHEDULER_SNOOZE_EN
                        if (snooze_hit) begin
                            state    <= CH_SNOOZE;
                            wait_cnt <= '0;
                            snz_cnt  <= SNZ_W'(SNOOZE_TICKS);
                        end else
`endif
                        if (tick) begin
                            if (expire || timeout) missed <= missed_inc;
                            if (expire) begin
                                wait_cnt <= '0;
                            end else if (timeout) begin
                                state    <= CH_COUNT;
                                wait_cnt <= '0;
                            end else begin
                                wait_cnt <= wait_nxt;
                            end
                        end
                    end
`ifdef MULTI_DOSE_SCHEDULER_SNOOZE_EN
                    CH_SNOOZE: begin
                        if (tick) begin
                            if (expire) begin
                                missed   <= missed_inc;
                                state    <= CH_ALARM;
                                wait_cnt <= '0;
                            end else if (snz_cnt == SNZ_W'(1)) begin
                                state    <= CH_ALARM;
                                wait_cnt <= '0;
                            end else begin
                                snz_cnt  <= snz_cnt - 1'b1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_dose_scheduler.sv
// N_CHAN-channel medication scheduler: run flag, per-channel timers, registered priority alarm.
// Optional snooze support via MULTI_DOSE_SCHEDULER_SNOOZE_EN.
module multi_dose_scheduler
    import multi_dose_pkg::*;
#(
    parameter int N_CHAN       = DEF_N_CHAN,
    parameter int CNT_W        = 17,
    parameter int DOSE_W       = 4,
    parameter int MISS_W       = 4,
    parameter int ACK_TIMEOUT  = 900,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick_1s,
    input  logic                       demo_mode,
    input  logic                       cfg_we,
    input  logic [$clog2(N_CHAN)-1:0]  cfg_chan,
    input  logic [CNT_W-1:0]           cfg_interval,
    input  logic [DOSE_W-1:0]          cfg_dose,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       ack,
    input  logic                       snooze,
    output logic [N_CHAN-1:0]          pending,
    output logic                       alarm_any,
    output logic [$clog2(N_CHAN)-1:0]  alarm_id,
    output logic [DOSE_W-1:0]          alarm_dose,
    output logic [N_CHAN*MISS_W-1:0]   missed_cnt
);

    localparam int ID_W = $clog2(N_CHAN);

    logic                           run;
    logic                           tick_adv;
    logic [N_CHAN-1:0]              cfg_hit;
    logic [N_CHAN-1:0]              ack_hit;
    logic [N_CHAN-1:0]              snooze_hit;
    logic [N_CHAN-1:0][DOSE_W-1:0]  dose;
    logic [ID_W-1:0]                pick_id;
    logic [DOSE_W-1:0]              pick_dose;

    assign tick_adv = (demo_mode | tick_1s) & run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     run <= 1'b0;
        else if (pause) run <= 1'b0;
        else if (start) run <= 1'b1;
    end

    // ack/snooze target the channel presented on the registered outputs.
    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
        assign cfg_hit[i]    = cfg_we && (cfg_chan == ID_W'(i));
        assign ack_hit[i]    = ack && alarm_any && (alarm_id == ID_W'(i));
        assign snooze_hit[i] = snooze && alarm_any && (alarm_id == ID_W'(i));

        dose_channel #(
            .CNT_W        (CNT_W),
            .DOSE_W       (DOSE_W),
            .MISS_W       (MISS_W),
            .ACK_TIMEOUT  (ACK_TIMEOUT),
            .SNOOZE_TICKS (SNOOZE_TICKS)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick_adv),
            .cfg_hit      (cfg_hit[i]),
            .cfg_interval (cfg_interval),
            .cfg_dose     (cfg_dose),
            .ack_hit      (ack_hit[i]),
            .snooze_hit   (snooze_hit[i]),
            .pending      (pending[i]),
            .dose         (dose[i]),
            .missed       (missed_cnt[i*MISS_W +: MISS_W])
        );
    end

    always_comb begin
        pick_id   = '0;
        pick_dose = '0;
        for (int k = N_CHAN - 1; k >= 0; k--) begin
            if (pending[k]) begin
                pick_id   = ID_W'(k);
                pick_dose = dose[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_any  <= 1'b0;
            alarm_id   <= '0;
            alarm_dose <= '0;
        end else begin
            alarm_any  <= |pending;
            alarm_id   <= pick_id;
            alarm_dose <= pick_dose;
        end
    end

endmodule

// File: tb/tb_multi_dose_scheduler.sv
// Self-checking bench for multi_dose_scheduler: directed scenarios plus random traffic vs a dose-level model.
module tb_multi_dose_scheduler;

    localparam int N    = 4;
    localparam int CW   = 17;
    localparam int DW   = 4;
    localparam int MW   = 4;
    localparam int TO   = 4;
    localparam int SNZ  = 3;
    localparam int MAXM = (1 << MW) - 1;
`ifdef MULTI_DOSE_SCHEDULER_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, tick_1s = 1'b0, demo_mode = 1'b0, cfg_we = 1'b0;
    logic [1:0]    cfg_chan = '0;
    logic [CW-1:0] cfg_interval = '0;
    logic [DW-1:0] cfg_dose = '0;
    logic          start = 1'b0, pause = 1'b0, ack = 1'b0, snooze = 1'b0;
    logic [N-1:0]    pending;
    logic            alarm_any;
    logic [1:0]      alarm_id;
    logic [DW-1:0]   alarm_dose;
    logic [N*MW-1:0] missed_cnt;

    int checks = 0;
    int errors = 0;

    multi_dose_scheduler #(
        .N_CHAN(N), .CNT_W(CW), .DOSE_W(DW), .MISS_W(MW), .ACK_TIMEOUT(TO), .SNOOZE_TICKS(SNZ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .demo_mode(demo_mode),
        .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_interval(cfg_interval), .cfg_dose(cfg_dose),
        .start(start), .pause(pause), .ack(ack), .snooze(snooze),
        .pending(pending), .alarm_any(alarm_any), .alarm_id(alarm_id),
        .alarm_dose(alarm_dose), .missed_cnt(missed_cnt)
    );

    always #5 clk = ~clk;

    // Model: each channel is an interval, time-left, time-since-alarm, alarm/snooze flags.
    int m_int[N], m_rem[N], m_wait[N], m_miss[N], m_dose[N], m_snz[N];
    bit m_alarm[N];
    bit m_run, m_any;
    int m_id, m_adose;

    function automatic void m_reset();
        for (int k = 0; k < N; k++) begin
            m_int[k] = 0; m_rem[k] = 0; m_wait[k] = 0; m_miss[k] = 0;
            m_dose[k] = 0; m_snz[k] = 0; m_alarm[k] = 0;
        end
        m_run = 0; m_any = 0; m_id = 0; m_adose = 0;
    endfunction

    function automatic logic [N-1:0] m_pv();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = m_alarm[k];
        return r;
    endfunction

    function automatic logic [N*MW-1:0] m_mv();
        logic [N*MW-1:0] r;
        for (int k = 0; k < N; k++) r[k*MW +: MW] = MW'(m_miss[k]);
        return r;
    endfunction

    function automatic void m_step();
        logic [N-1:0] pv;
        bit adv, any_q, hit_ack, hit_snz, ex;
        int id_q;
        pv    = m_pv();
        adv   = (demo_mode || tick_1s) && m_run;
        any_q = m_any;
        id_q  = m_id;
        m_any = |pv; m_id = 0; m_adose = 0;
        for (int k = N - 1; k >= 0; k--) if (pv[k]) begin m_id = k; m_adose = m_dose[k]; end
        if (pause) m_run = 0;
        else if (start) m_run = 1;
        for (int i = 0; i < N; i++) begin
            hit_ack = ack && any_q && (id_q == i);
            hit_snz = SNZ_EN && snooze && any_q && (id_q == i);
            if (cfg_we && (int'(cfg_chan) == i)) begin
                m_int[i] = int'(cfg_interval); m_rem[i] = int'(cfg_interval);
                m_dose[i] = int'(cfg_dose); m_wait[i] = 0; m_alarm[i] = 0; m_snz[i] = 0;
            end else if (m_int[i] != 0) begin
                ex = adv && (m_rem[i] == 1);
                if (adv) m_rem[i] = ex ? m_int[i] : m_rem[i] - 1;
                if (hit_ack) begin
                    m_alarm[i] = ex; m_snz[i] = 0; m_wait[i] = 0;
                end else if (m_alarm[i]) begin
                    if (hit_snz) begin
                        m_alarm[i] = 0; m_snz[i] = SNZ; m_wait[i] = 0;
                    end else if (adv) begin
                        m_wait[i]++;
                        if (ex || m_wait[i] == TO) begin
                            if (m_miss[i] < MAXM) m_miss[i]++;
                            m_wait[i] = 0; m_alarm[i] = ex;
                        end
                    end
                end else if (m_snz[i] > 0) begin
                    if (adv) begin
                        if (ex) begin
                            if (m_miss[i] < MAXM) m_miss[i]++;
                            m_alarm[i] = 1; m_snz[i] = 0; m_wait[i] = 0;
                        end else if (m_snz[i] == 1) begin
                            m_alarm[i] = 1; m_snz[i] = 0; m_wait[i] = 0;
                        end else m_snz[i]--;
                    end
                end else if (ex) begin
                    m_alarm[i] = 1; m_wait[i] = 0;
                end
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic do_cfg(input int ch, input int iv, input int d);
        cfg_we = 1'b1; cfg_chan = 2'(ch); cfg_interval = CW'(iv); cfg_dose = DW'(d);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start(); start = 1'b1; cycle(); start = 1'b0; endtask
    task automatic pulse_pause(); pause = 1'b1; cycle(); pause = 1'b0; endtask
    task automatic pulse_ack();   ack = 1'b1;   cycle(); ack = 1'b0;   endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({pending, alarm_any, alarm_id, alarm_dose, missed_cnt} !== '0) begin
            errors++; $display("FAIL reset_hold outputs=%h want 0", {pending, alarm_any, alarm_id, alarm_dose, missed_cnt});
        end
        m_reset();
        @(negedge clk); rst_n = 1'b1;
        cycle();
        checks++;
        if ({pending, alarm_any, alarm_id, alarm_dose, missed_cnt} !== '0) begin
            errors++; $display("FAIL reset_release outputs=%h want 0", {pending, alarm_any, alarm_id, alarm_dose, missed_cnt});
        end
    endtask

    task automatic test_first_alarm();
        bit early;
        demo_mode = 1'b1;
        do_cfg(0, 5, 2);
        pulse_start();
        early = 0;
        for (int k = 0; k < 4; k++) begin cycle(); if (pending !== 4'b0000) early = 1; end
        checks++;
        if (early) begin errors++; $display("FAIL first_early pending rose before 5 ticks"); end
        cycle();
        checks++;
        if (pending !== 4'b0001 || alarm_any !== 1'b0) begin
            errors++; $display("FAIL first_pending pending=%b any=%b want 0001/0", pending, alarm_any);
        end
        cycle();
        checks++;
        if (alarm_any !== 1'b1 || alarm_id !== 2'd0 || alarm_dose !== 4'd2) begin
            errors++; $display("FAIL first_present any=%b id=%0d dose=%0d want 1/0/2", alarm_any, alarm_id, alarm_dose);
        end
        pulse_ack();
        checks++;
        if (pending[0] !== 1'b0) begin errors++; $display("FAIL first_ack pending0=%b want 0", pending[0]); end
    endtask

    task automatic test_priority();
        pulse_pause();
        do_cfg(0, 0, 0);
        do_cfg(1, 3, 1);
        do_cfg(2, 3, 2);
        pulse_start();
        cycle(); cycle(); cycle();
        checks++;
        if (pending !== 4'b0110) begin errors++; $display("FAIL prio_pending pending=%b want 0110", pending); end
        pulse_pause();
        checks++;
        if (alarm_any !== 1'b1 || alarm_id !== 2'd1 || alarm_dose !== 4'd1) begin
            errors++; $display("FAIL prio_first any=%b id=%0d dose=%0d want 1/1/1", alarm_any, alarm_id, alarm_dose);
        end
        pulse_ack();
        checks++;
        if (pending !== 4'b0100) begin errors++; $display("FAIL prio_ack1 pending=%b want 0100", pending); end
        cycle();
        checks++;
        if (alarm_id !== 2'd2 || alarm_dose !== 4'd2) begin
            errors++; $display("FAIL prio_second id=%0d dose=%0d want 2/2", alarm_id, alarm_dose);
        end
        pulse_ack();
        cycle();
        checks++;
        if (pending !== 4'b0000 || alarm_any !== 1'b0) begin
            errors++; $display("FAIL prio_clear pending=%b any=%b want 0000/0", pending, alarm_any);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_cfg(1, 0, 0);
        do_cfg(2, 0, 0);
        do_cfg(0, 100, 3);
        pulse_start();
        for (int r = 0; r < 16; r++) begin
            for (n = 0; n < 200 && pending[0] !== 1'b1; n++) cycle();
            checks++;
            if (pending[0] !== 1'b1) begin errors++; $display("FAIL timeout_wait round=%0d no alarm", r); end
            cycle(); cycle(); cycle();
            checks++;
            if (pending[0] !== 1'b1) begin errors++; $display("FAIL timeout_early round=%0d pending0=0 want 1", r); end
            cycle();
            checks++;
            if (pending[0] !== 1'b0 || missed_cnt[3:0] !== MW'(r < MAXM ? r + 1 : MAXM)) begin
                errors++; $display("FAIL timeout_miss round=%0d pending0=%b missed=%0d want 0/%0d",
                                   r, pending[0], missed_cnt[3:0], (r < MAXM ? r + 1 : MAXM));
            end
        end
        checks++;
        if (missed_cnt[3:0] !== 4'd15) begin errors++; $display("FAIL timeout_sat missed=%0d want 15", missed_cnt[3:0]); end
    endtask

    task automatic test_pause();
        bit rose;
        for (int n = 0; n < 150 && m_rem[0] != 3; n++) cycle();
        pulse_pause();
        rose = 0;
        for (int k = 0; k < 50; k++) begin cycle(); if (pending !== 4'b0000) rose = 1; end
        checks++;
        if (rose) begin errors++; $display("FAIL pause_hold alarm raised while paused"); end
        pulse_start();
        cycle();
        checks++;
        if (pending[0] !== 1'b0) begin errors++; $display("FAIL pause_resume1 pending0=1 want 0"); end
        cycle();
        checks++;
        if (pending[0] !== 1'b1) begin errors++; $display("FAIL pause_resume2 pending0=0 want 1"); end
        start = 1'b1; pause = 1'b1; cycle(); start = 1'b0; pause = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        checks++;
        if (pending[0] !== 1'b1 || missed_cnt[3:0] !== 4'd15) begin
            errors++; $display("FAIL pause_wins pending0=%b missed=%0d want 1/15", pending[0], missed_cnt[3:0]);
        end
    endtask

    task automatic test_cfg_override();
        int n;
        bit early;
        do_cfg(0, 0, 0);
        do_cfg(1, 6, 4);
        pulse_start();
        for (n = 0; n < 100 && !(m_alarm[1] && m_wait[1] == 3 && m_any && m_id == 1); n++) cycle();
        checks++;
        if (alarm_any !== 1'b1 || alarm_id !== 2'd1) begin
            errors++; $display("FAIL ovr_setup any=%b id=%0d want 1/1", alarm_any, alarm_id);
        end
        ack = 1'b1;
        do_cfg(1, 9, 7);
        ack = 1'b0;
        checks++;
        if (pending[1] !== 1'b0 || missed_cnt[7:4] !== 4'd0) begin
            errors++; $display("FAIL ovr_same_cycle pending1=%b missed1=%0d want 0/0", pending[1], missed_cnt[7:4]);
        end
        early = 0;
        for (int k = 0; k < 8; k++) begin cycle(); if (pending[1] !== 1'b0) early = 1; end
        checks++;
        if (early) begin errors++; $display("FAIL ovr_reload alarm before reloaded interval"); end
        cycle();
        checks++;
        if (pending[1] !== 1'b1) begin errors++; $display("FAIL ovr_expire pending1=0 want 1"); end
        cycle();
        checks++;
        if (alarm_dose !== 4'd7 || missed_cnt[7:4] !== 4'd0) begin
            errors++; $display("FAIL ovr_dose dose=%0d missed1=%0d want 7/0", alarm_dose, missed_cnt[7:4]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pending, alarm_any, alarm_id, alarm_dose, missed_cnt} !== '0) begin
            errors++; $display("FAIL async_reset outputs=%h want 0", {pending, alarm_any, alarm_id, alarm_dose, missed_cnt});
        end
        m_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        pulse_start();
        for (int c = 0; c < 1500; c++) begin
            demo_mode    = ($urandom_range(0, 3) != 0);
            tick_1s      = 1'($urandom_range(0, 1));
            cfg_we       = ($urandom_range(0, 15) == 0);
            cfg_chan     = 2'($urandom_range(0, 3));
            cfg_interval = CW'($urandom_range(0, 12));
            cfg_dose     = DW'($urandom_range(0, 15));
            start        = ($urandom_range(0, 7) == 0);
            pause        = ($urandom_range(0, 19) == 0);
            ack          = ($urandom_range(0, 5) == 0);
            snooze       = ($urandom_range(0, 7) == 0);
            cycle();
            checks++;
            if ({pending, alarm_any, alarm_id, alarm_dose, missed_cnt} !==
                {m_pv(), m_any, 2'(m_id), DW'(m_adose), m_mv()}) begin
                errors++;
                if (bad < 5) $display("FAIL random cyc=%0d got p=%b a=%b id=%0d d=%0d m=%h want p=%b a=%b id=%0d d=%0d m=%h",
                    c, pending, alarm_any, alarm_id, alarm_dose, missed_cnt,
                    m_pv(), m_any, m_id, m_adose, m_mv());
                bad++;
            end
        end
        {cfg_we, start, pause, ack, snooze, tick_1s} = '0;
        demo_mode = 1'b1;
    endtask

`ifdef MULTI_DOSE_SCHEDULER_SNOOZE_EN
    task automatic test_snooze();
        int n;
        bit rose;
        @(negedge clk); rst_n = 1'b0; m_reset();
        @(negedge clk); rst_n = 1'b1;
        do_cfg(0, 50, 6);
        pulse_start();
        for (n = 0; n < 100 && alarm_any !== 1'b1; n++) cycle();
        snooze = 1'b1; cycle(); snooze = 1'b0;
        rose = (pending[0] !== 1'b0);
        cycle(); if (pending[0] !== 1'b0) rose = 1;
        cycle(); if (pending[0] !== 1'b0) rose = 1;
        checks++;
        if (rose) begin errors++; $display("FAIL snooze_hold pending0 rose during snooze"); end
        cycle();
        checks++;
        if (pending[0] !== 1'b1 || missed_cnt[3:0] !== 4'd0) begin
            errors++; $display("FAIL snooze_reraise pending0=%b missed=%0d want 1/0", pending[0], missed_cnt[3:0]);
        end
    endtask
`endif

    initial begin
        m_reset();
        test_reset();
        test_first_alarm();
        test_priority();
        test_timeout();
        test_pause();
        test_cfg_override();
        test_random();
`ifdef MULTI_DOSE_SCHEDULER_SNOOZE_EN
        test_snooze();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
